// File: rtl/tanh_in_requant_stage.sv
// Requantizes signed accumulator samples to 4-bit tanh input codes and queues
// them in a 2-entry FIFO whose head register drives the tanh In[3:0] port.
module tanh_in_requant_stage #(
  parameter int IN_W      = 16,
  parameter int SHIFT     = 8,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr_stats,
  output logic                 sat_flag,
  output logic [SAT_CNT_W-1:0] sat_count
);

  localparam int EXT_W = IN_W + 1;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  localparam logic signed [EXT_W-1:0] CODE_MAX = EXT_W'(7);
  localparam logic signed [EXT_W-1:0] CODE_MIN = EXT_W'(-8);

  // ------------------------------------------------------------------
  // Quantization: one extra bit of headroom keeps the rounding add exact
  // ------------------------------------------------------------------
  logic signed [EXT_W-1:0] ext_data;
  logic signed [EXT_W-1:0] rounded;
  logic                    sat_hi;
  logic                    sat_lo;
  logic                    sat;
  logic [3:0]              code;

  assign ext_data = {in_data[IN_W-1], in_data};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
      logic signed [EXT_W-1:0] biased;
      assign biased  = ext_data + HALF;
      assign rounded = biased >>> SHIFT;
    end else begin : g_pass
      assign rounded = ext_data;
    end
  endgenerate

  always_comb begin
    sat_hi = (rounded > CODE_MAX);
    sat_lo = (rounded < CODE_MIN);
    sat    = sat_hi | sat_lo;
    if (sat_hi) begin
      code = 4'h7;
    end else if (sat_lo) begin
      code = 4'h8;
    end else begin
      code = rounded[3:0];
    end
  end

  // ------------------------------------------------------------------
  // Handshake and occupancy
  // ------------------------------------------------------------------
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] wr_idx;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // A pop shifts everything down one slot, so the write lands one lower.
  assign wr_idx = pop ? (count_reg - CNT_W'(1)) : count_reg;

  // Ready and valid come straight from flops derived from the next occupancy,
  // so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      in_ready_reg  <= (count_next < CNT_W'(DEPTH));
      out_valid_reg <= (count_next != '0);
    end
  end

  // ------------------------------------------------------------------
  // Shift-register storage: slot 0 is always the head
  // ------------------------------------------------------------------
  logic [3:0] entry_vals [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [3:0] slot_reg;
      logic [3:0] slot_next;

      if (gi < DEPTH - 1) begin : g_mid
        always_comb begin
          slot_next = slot_reg;
          if (push && (wr_idx == CNT_W'(gi))) begin
            slot_next = code;
          end else if (pop) begin
            slot_next = entry_vals[gi+1];
          end
        end
      end else begin : g_last
        always_comb begin
          slot_next = slot_reg;
          if (push && (wr_idx == CNT_W'(gi))) begin
            slot_next = code;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= 4'h0;
        end else begin
          slot_reg <= slot_next;
        end
      end

      assign entry_vals[gi] = slot_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Saturation statistics; a clear wins over a coincident increment
  // ------------------------------------------------------------------
  logic                 sat_flag_reg;
  logic [SAT_CNT_W-1:0] sat_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag_reg  <= 1'b0;
      sat_count_reg <= '0;
    end else begin
      if (push) begin
        sat_flag_reg <= sat;
      end
      if (clr_stats) begin
        sat_count_reg <= '0;
      end else if (push && sat && !(&sat_count_reg)) begin
        sat_count_reg <= sat_count_reg + SAT_CNT_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = entry_vals[0];
  assign sat_flag  = sat_flag_reg;
  assign sat_count = sat_count_reg;

endmodule
